// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: idle-driven clock-gate controller.
// The FSM walks RUN -> DRAIN -> GATED -> WAKE -> RUN. In DRAIN it counts idle cycles
// before it asks for the clock to be masked. The mask control (enable) comes from a
// falling-edge flop, so the downstream AND-style mask only switches while clk_i is low.
// Optional feature macro: CLK_GATE_AUTO_EN. When it is defined, the block gates
// automatically whenever busy is low, and gate_req no longer aborts a drain or a gate.
// Legal parameters: 1 <= IDLE_CYC, WAKE_CYC <= 2^CNT_W-1.
module clk_gate_ctrl #(
  parameter int IDLE_CYC = 4,
  parameter int WAKE_CYC = 2,
  parameter int CNT_W    = 4
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       gate_req,
  input  logic       busy,
  input  logic       wake_i,
  output logic       enable,
  output logic       gate_ack,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    GATED = 2'd2,
    WAKE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYC - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'(WAKE_CYC - 1);

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
  logic             drain_go, drain_abort, gated_exit;

  // Entry, abort and exit qualifiers. These are the only places the optional mode shows up.
`ifdef CLK_GATE_AUTO_EN
  // Any idle cycle starts a drain. An explicit gate_req is a subset of that case.
  assign drain_go    = ~busy | (gate_req & ~busy);
  assign drain_abort = busy;
  assign gated_exit  = wake_i | busy;
`else
  assign drain_go    = gate_req & ~busy;
  assign drain_abort = busy | ~gate_req;
  assign gated_exit  = wake_i | ~gate_req;
`endif

  // The counter saturates at all-ones. It never wraps back to zero.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  // Next-state and counter logic. busy wins over the terminal drain count because it is tested first.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      RUN: begin
        if (drain_go) begin
          state_nx = DRAIN;
          cnt_nx   = '0;
        end
      end
      DRAIN: begin
        if (drain_abort) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else if (cnt == IDLE_LAST) begin
          state_nx = GATED;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      GATED: begin
        if (gated_exit) begin
          state_nx = WAKE;
          cnt_nx   = '0;
        end
      end
      WAKE: begin
        if (cnt == WAKE_LAST) begin
          state_nx = RUN;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc;
        end
      end
      default: begin
        state_nx = RUN;
        cnt_nx   = '0;
      end
    endcase
  end

  // State, counter and ack registers. gate_ack mirrors the GATED state cycle for cycle.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      cnt      <= '0;
      gate_ack <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      gate_ack <= (state_nx == GATED);
    end
  end

  // The mask control is captured on the falling edge, so it only moves during the low phase.
  // Reset clears it at once, with no clock edge needed.
  always_ff @(negedge clk_i or negedge rst_n) begin
    if (!rst_n) enable <= 1'b0;
    else        enable <= (state == GATED);
  end

  assign state_o = state;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Scoreboard bench for clk_gate_ctrl in its default build.
// Each step drives the inputs and pushes the expected post-edge state onto a queue.
// After the rising edge the entry is popped and compared. The enable output is checked
// on both phases, so a change during the high phase is caught.
module tb_clk_gate_ctrl;
  localparam int IDLE_CYC = 4;
  localparam int WAKE_CYC = 2;
  localparam logic [1:0] S_RUN = 2'd0, S_DRAIN = 2'd1, S_GATED = 2'd2, S_WAKE = 2'd3;

  typedef struct packed {
    logic [1:0] st;
    logic       ack;
  } exp_t;

  logic       clk_i = 1'b0;
  logic       rst_n, gate_req, busy, wake_i;
  logic       enable, gate_ack;
  logic [1:0] state_o;

  clk_gate_ctrl #(.IDLE_CYC(IDLE_CYC), .WAKE_CYC(WAKE_CYC), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_n(rst_n), .gate_req(gate_req), .busy(busy), .wake_i(wake_i),
    .enable(enable), .gate_ack(gate_ack), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  int         n_cmp = 0;
  int         n_bad = 0;
  exp_t       exp_q[$];
  logic [1:0] m_st;
  int         m_idle, m_wake;
  logic       en_prev;

  // Compare one observed value against its expected value and count the result.
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. It tracks the run of qualifying idle edges and the wake cycles left.
  task automatic model(input logic g, input logic b, input logic w);
    logic q, ex;
`ifdef CLK_GATE_AUTO_EN
    q  = ~b;
    ex = w | b;
`else
    q  = g & ~b;
    ex = w | ~g;
`endif
    case (m_st)
      S_GATED: if (ex) begin m_st = S_WAKE; m_wake = WAKE_CYC; end
      S_WAKE: begin
        m_wake--;
        if (m_wake == 0) begin m_st = S_RUN; m_idle = 0; end
      end
      default: begin
        m_idle = q ? m_idle + 1 : 0;
        if (m_idle == 0)            m_st = S_RUN;
        else if (m_idle > IDLE_CYC) begin m_st = S_GATED; m_idle = 0; end
        else                        m_st = S_DRAIN;
      end
    endcase
  endtask

  // One clock cycle. It starts just after a falling edge and ends just after the next one.
  task automatic step(input logic g, input logic b, input logic w);
    exp_t e;
    gate_req = g; busy = b; wake_i = w;
    model(g, b, w);
    exp_q.push_back('{st: m_st, ack: (m_st == S_GATED)});
    @(posedge clk_i); #1;
    e = exp_q.pop_front();
    chk("state", 8'(state_o), 8'(e.st));
    chk("gate_ack", 8'(gate_ack), 8'(e.ack));
    chk("enable_high_phase", 8'(enable), 8'(en_prev));
    @(negedge clk_i); #1;
    en_prev = (m_st == S_GATED);
    chk("enable_low_phase", 8'(enable), 8'(en_prev));
  endtask

  task automatic reset_model();
    m_st = S_RUN; m_idle = 0; m_wake = 0; en_prev = 1'b0;
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; gate_req = 1'b0; busy = 1'b0; wake_i = 1'b0;
    reset_model();
    #3;
    chk("rst_state", 8'(state_o), 8'd0);
    chk("rst_ack", 8'(gate_ack), 8'd0);
    chk("rst_enable", 8'(enable), 8'd0);
    repeat (2) @(negedge clk_i);
    rst_n = 1'b1; #1;

    // gate_req is held and the block is idle, so GATED is reached on edge 5. busy is then ignored.
    repeat (5) step(1, 0, 0);
    step(1, 1, 0);
    step(1, 0, 0);
    // Dropping gate_req gives two WAKE cycles, then RUN.
    repeat (4) step(0, 0, 0);
    // A busy pulse at drain count 2 aborts the drain. A full drain follows.
    repeat (3) step(1, 0, 0);
    step(1, 1, 0);
    repeat (6) step(1, 0, 0);
    // wake_i with gate_req still high: WAKE, RUN, then a new drain and re-gate.
    step(1, 0, 1);
    repeat (8) step(1, 0, 0);
    // busy at the terminal drain count wins, and the FSM returns to RUN.
    repeat (3) step(0, 0, 0);
    repeat (4) step(1, 0, 0);
    step(1, 1, 0);
    step(0, 0, 0);
    // wake_i during WAKE is ignored.
    repeat (5) step(1, 0, 0);
    step(0, 0, 0);
    step(1, 0, 1);
    repeat (2) step(0, 0, 0);

    // Mixed random traffic.
    for (int i = 0; i < 80; i++)
      step($urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);

    // Reach GATED, then assert reset in the middle of the high phase.
    repeat (2) step(0, 0, 0);
    repeat (6) step(1, 0, 0);
    chk("pre_reset_gated", 8'(state_o), 8'(S_GATED));
    @(posedge clk_i); #2;
    rst_n = 1'b0; #1;
    chk("async_rst_enable", 8'(enable), 8'd0);
    chk("async_rst_ack", 8'(gate_ack), 8'd0);
    chk("async_rst_state", 8'(state_o), 8'd0);
    @(negedge clk_i); #1;
    reset_model();
    rst_n = 1'b1;
    // The first edge after reset release already evaluates a transition.
    step(1, 0, 0);
    repeat (5) step(1, 0, 0);
    repeat (3) step(0, 0, 0);

    if (exp_q.size() != 0) chk("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
